// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries with synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int CW     = $clog2(QDEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(QDEPTH);

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign do_pop = pop_i & (count_q != '0);

  // Pointers are log2(QDEPTH) wide, so incrementing wraps at QDEPTH for free.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush_i && push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush_i && push_i && !do_pop) assert (count_q < CW'(QDEPTH));
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues to a 1-cycle synchronous imem
// and buffers responses in a small queue feeding the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       id_stall,
  output logic                       if_valid,
  output logic [31:0]                if_pc,
  output logic [31:0]                if_instr,
  output logic [$clog2(QDEPTH):0]    q_count
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         squash_q, squash_d;

  logic         pop;
  logic         issue;
  logic         push;
  logic [CW:0]  credit_used;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign pop = if_valid & ~id_stall;

  // Entries already held plus the one coming back, minus the one leaving now.
  assign credit_used = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue = (state_q == RUN) & ~redirect_valid & (credit_used < (CW+1)'(QDEPTH));
  assign push  = inflight_q & ~squash_q & ~redirect_valid;

  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    squash_d      = 1'b0;
    if (state_q == BOOT) state_d = RUN;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      squash_d = inflight_q;
    end else if (issue) begin
      pc_d          = pc_q + PC_STEP;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH),
    .CW    (CW)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (q_count)
  );

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign if_valid  = (q_count != '0);
  assign if_pc     = head.pc;
  assign if_instr  = head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed cycle table, a wrap-around
// instance, and a randomized run against a stream-order reference model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        redirect_valid, redirect_valid2;
  logic [31:0] redirect_pc, redirect_pc2;
  logic        id_stall, id_stall2;
  logic        if_valid, if_valid2;
  logic [31:0] if_pc, if_pc2;
  logic [31:0] if_instr, if_instr2;
  logic [1:0]  q_count, q_count2;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .q_count(q_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .id_stall(id_stall2),
    .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2), .q_count(q_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: data for a request appears the next cycle.
  always @(posedge clk) begin
    imem_rdata  <= imem_addr + 32'h100;
    imem_rdata2 <= imem_addr2 + 32'h100;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        chk;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    logic [1:0]  expCount;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(input logic rst, stall, redir, input logic [31:0] rpc,
                               input logic chk, expReq, input logic [31:0] expAddr,
                               input logic expValid, input logic [31:0] expPc,
                               input logic [1:0] expCount);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc; v.chk = chk;
    v.expReq = expReq; v.expAddr = expAddr; v.expValid = expValid;
    v.expPc = expPc; v.expCount = expCount;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, stall, redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset          = rst;
    id_stall       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #3;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  logic [31:0] expNext;
  logic [31:0] expIssue;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;
  int          pops;

  initial begin
    reset = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    id_stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;

    // rst stall redir rpc chk | req addr valid pc count
    vecs.push_back(row(0,0,0,32'h0 ,1, 0,32'h0 ,0,32'h0 ,0)); // R0 BOOT
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h0 ,0,32'h0 ,0));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h4 ,0,32'h0 ,0));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h8 ,1,32'h0 ,1));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'hC ,1,32'h4 ,1));
    vecs.push_back(row(0,1,0,32'h0 ,1, 0,32'h0 ,1,32'h8 ,1)); // R5 stall
    vecs.push_back(row(0,1,0,32'h0 ,1, 0,32'h0 ,1,32'h8 ,2));
    vecs.push_back(row(0,1,0,32'h0 ,1, 0,32'h0 ,1,32'h8 ,2));
    vecs.push_back(row(0,1,0,32'h0 ,1, 0,32'h0 ,1,32'h8 ,2));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h10,1,32'h8 ,2)); // R9 release
    vecs.push_back(row(0,0,1,32'h40,1, 0,32'h0 ,1,32'hC ,1)); // R10 redirect, 0x10 in flight
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h40,0,32'h0 ,0));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h44,0,32'h0 ,0));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h48,1,32'h40,1));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h4C,1,32'h44,1));
    vecs.push_back(row(0,1,0,32'h0 ,1, 0,32'h0 ,1,32'h48,1)); // R15
    vecs.push_back(row(0,1,0,32'h0 ,1, 0,32'h0 ,1,32'h48,2));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h50,1,32'h48,2)); // R17 request 0x50 issued
    vecs.push_back(row(1,0,0,32'h0 ,0, 0,32'h0 ,0,32'h0 ,0)); // R18 reset mid-stream
    vecs.push_back(row(0,0,0,32'h0 ,1, 0,32'h0 ,0,32'h0 ,0));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h0 ,0,32'h0 ,0));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h4 ,0,32'h0 ,0));
    vecs.push_back(row(0,0,0,32'h0 ,1, 1,32'h8 ,1,32'h0 ,1));

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      if (vecs[i].chk) begin
        checkOutput($sformatf("row%0d_req", i), 32'(imem_req), 32'(vecs[i].expReq));
        if (vecs[i].expReq) checkOutput($sformatf("row%0d_addr", i), imem_addr, vecs[i].expAddr);
        checkOutput($sformatf("row%0d_valid", i), 32'(if_valid), 32'(vecs[i].expValid));
        checkOutput($sformatf("row%0d_pc", i), if_pc, vecs[i].expValid ? vecs[i].expPc : 32'h0);
        checkOutput($sformatf("row%0d_instr", i), if_instr,
                    vecs[i].expValid ? vecs[i].expPc + 32'h100 : 32'h0);
        checkOutput($sformatf("row%0d_count", i), 32'(q_count), 32'(vecs[i].expCount));
      end
      if (i >= 1 && i <= 3)
        checkOutput($sformatf("wrap_addr%0d", i), imem_addr2, 32'hFFFF_FFF8 + 32'(4 * (i - 1)));
      if (i >= 3 && i <= 5) begin
        checkOutput($sformatf("wrap_valid%0d", i), 32'(if_valid2), 32'h1);
        checkOutput($sformatf("wrap_pc%0d", i), if_pc2, 32'hFFFF_FFF8 + 32'(4 * (i - 3)));
      end
    end

    // Randomized run: popped entries must form the sequential stream from the
    // last reset/redirect target, and issued addresses must follow the same rule.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    expNext  = 32'h0;
    expIssue = 32'h0;
    pops     = 0;
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom() & 32'hFFFF_FFFC;
      applyStimulus(1'b0, stall, redir, rpc);
      if (redir) checkOutput("rnd_redir_noreq", 32'(imem_req), 32'h0);
      if (imem_req) begin
        checkOutput("rnd_issue_addr", imem_addr, expIssue);
        expIssue = expIssue + 32'd4;
      end
      checkOutput("rnd_count_bound", 32'(q_count <= 2'd2), 32'h1);
      if (if_valid && !stall) begin
        checkOutput("rnd_pop_pc", if_pc, expNext);
        checkOutput("rnd_pop_instr", if_instr, expNext + 32'h100);
        expNext = expNext + 32'd4;
        pops++;
      end
      if (redir) begin
        expNext  = rpc;
        expIssue = rpc;
      end
    end
    checkOutput("rnd_throughput", 32'(pops >= 150), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a synchronous-read instruction memory.
- Buffers returned instructions in a small queue.
- Presents {pc, instr, valid} to IF/ID with stall back-pressure and branch/jump redirect from the EX/MEM stage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, PC increment per sequential fetch.
- QDEPTH, 2, fetch-queue entries (power of 2, minimum 2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  32  fetch address; valid when imem_req=1.
- imem_rdata  in  32  instruction for the request of the previous cycle.
- redirect_valid  in  1  taken branch/jump from EX/MEM.
- redirect_pc  in  32  redirect target.
- id_stall  in  1  IF/ID hold; the head entry is not consumed.
- if_valid  out  1  head entry valid; drives the IF/ID write enable.
- if_pc  out  32  PC of the head entry.
- if_instr  out  32  instruction of the head entry.
- q_count  out  $clog2(QDEPTH)+1  queue occupancy.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high. Every state element is updated only on the rising edge of clk.
- Reset values: state=BOOT, pc=RESET_PC, queue empty, inflight=0, squash=0. Outputs: if_valid=0, if_pc=0, if_instr=0, q_count=0, imem_req=0.
- FSM states:
  - BOOT: imem_req=0; goes to RUN at the first edge with reset=0.
  - RUN: normal operation. No other states.
- Memory timing: 1-cycle synchronous read. A request in cycle N returns imem_rdata in cycle N+1. The inflight flag and inflight_pc record the outstanding request.
- pop = if_valid & ~id_stall.
- Issue rule (RUN only):
  - imem_req = ~redirect_valid & (q_count + inflight - pop < QDEPTH).
  - imem_addr = pc. On issue, pc <= pc + PC_STEP, wrapping mod 2^32.
  - At most one request is outstanding per cycle.
  - The credit rule guarantees the queue never overflows. Overflow is an assertion failure.
- Push: in the cycle after an issue, if squash=0, {inflight_pc, imem_rdata} is written to the tail at the edge. If squash=1, the response is dropped and squash clears.
- Output:
  - if_valid = (q_count != 0); if_pc/if_instr = head entry.
  - When the queue is empty, if_pc=0 and if_instr=0.
  - The output is registered queue state with no combinational path from imem_rdata.
- Simultaneous push and pop: both take effect; q_count is unchanged.
- Redirect (highest priority):
  - At the edge: queue cleared, pc <= redirect_pc.
  - squash <= inflight, so a response still in the memory is discarded.
  - No issue in the redirect cycle.
  - A pop in the redirect cycle is still honoured by IF/ID, since the head is consumed that edge. The upstream pipeline flushes IF/ID itself.
  - First fetch at redirect_pc occurs the cycle after the redirect.
  - A redirect during id_stall behaves identically.
  - Back-to-back redirects: the last one wins.
- Latency:
  - if_valid first rises 3 edges after the first edge with reset=0: BOOT->RUN, issue, push.
  - Redirect to if_valid: 2 edges after the redirect edge.
- Throughput: one instruction per cycle in steady state with id_stall=0.
- Stall: the queue fills to QDEPTH, then imem_req drops. Entries hold stable until id_stall deasserts.
- Reset mid-operation: all state returns to reset values at that edge. The in-flight response is ignored because inflight is cleared.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {BOOT, RUN}.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - Constants RESET_PC_DEF and PC_STEP_DEF.
- Sub-module fetch_queue: QDEPTH-entry circular FIFO of fetch_entry_t with push, pop, synchronous flush and count. Read and write pointers wrap at QDEPTH.
- fetch_stage holds the FSM, PC, inflight/squash tracking and the credit logic.

Test Plan:
- Boot sequence: reset 3 cycles then release; imem returns addr+0x100.
  - imem_addr 0,4,8 on consecutive cycles.
  - if_valid rises at the 3rd edge with if_pc=0, if_instr=0x100.
- Steady stream with id_stall=0 for 10 cycles: if_valid held high; if_pc increments by 4 every cycle with no bubbles.
- id_stall=1 for 4 cycles mid-stream:
  - q_count reaches 2 and imem_req=0 after the queue fills.
  - Head stays unchanged.
  - On release, the order continues with no duplicates or skips.
- redirect_valid with redirect_pc=0x40 while a request to 0x10 is in flight:
  - The 0x10 response is dropped and q_count=0 after the edge.
  - imem_addr=0x40 next cycle; if_pc=0x40 two edges after the redirect.
- PC wrap: RESET_PC=32'hFFFF_FFF8 gives the sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted with a full queue and a request in flight:
  - Next cycle if_valid=0 and q_count=0.
  - The stale response is not pushed; the boot sequence repeats from RESET_PC.
